// File: rtl/dff_rst.sv
// dff_rst: rising-edge D register with synchronous, active-high reset.
// Storage element of the 5-bit carry-lookahead adder datapath: it registers
// operands, carries and sums between stages. WIDTH independent bits are stored
// side by side. No enable, so every rising edge either resets or loads D.
// Q is taken straight from the register, so there is no combinational path
// from D or RST to Q.
`timescale 1ns/1ps

module dff_rst #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state is the data input, all bits in parallel with no cross-bit logic.
  always_comb begin
    q_d = D;
  end

  // Reset is sampled only at the rising edge and takes priority over D.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_dff_rst.sv
// tb_dff_rst: scoreboard bench for dff_rst. Two instances share the clock and
// reset: a default single-bit one and a 5-bit one with a non-zero reset value.
// Expected values are queued when inputs are driven and popped one quarter
// period after the next rising edge. Extra checks between edges confirm that
// Q holds across falling edges, mid-window D changes and reset changes.
`timescale 1ns/1ps

module tb_dff_rst;

  localparam logic [4:0] RV5 = 5'b10101;

  logic       CLK = 1'b0;
  logic       RST;
  logic       D1;
  logic       Q1;
  logic [4:0] D5;
  logic [4:0] Q5;

  // 1 ns period, first rising edge at 0.5 ns
  always #0.5 CLK = ~CLK;

  dff_rst u_dff1 (
    .CLK (CLK),
    .RST (RST),
    .D   (D1),
    .Q   (Q1)
  );

  dff_rst #(
    .WIDTH       (5),
    .RESET_VALUE (RV5)
  ) u_dff5 (
    .CLK (CLK),
    .RST (RST),
    .D   (D5),
    .Q   (Q5)
  );

  typedef struct packed {
    logic       e1;
    logic [4:0] e5;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs and queue the value the next rising edge must produce.
  task automatic drive(input logic rst, input logic d1, input logic [4:0] d5);
    exp_t e;
    RST = rst;
    D1  = d1;
    D5  = d5;
    e.e1 = rst ? 1'b0 : d1;
    e.e5 = rst ? RV5  : d5;
    sb_q.push_back(e);
  endtask

  // Wait for the rising edge, then compare a quarter period later.
  task automatic sample_pop(input string tag);
    @(posedge CLK);
    #0.25;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      last_exp = sb_q.pop_front();
      check_val({tag, "_q1"}, {4'b0000, Q1}, {4'b0000, last_exp.e1});
      check_val({tag, "_q5"}, Q5, last_exp.e5);
    end
  endtask

  // Q must still show the last captured value between edges.
  task automatic hold_chk(input string tag);
    check_val({tag, "_q1"}, {4'b0000, Q1}, {4'b0000, last_exp.e1});
    check_val({tag, "_q5"}, Q5, last_exp.e5);
  endtask

  // Drive 0.25 ns before an edge, check after it and again after the falling edge.
  task automatic cycle(input string tag, input logic rst, input logic d1, input logic [4:0] d5);
    drive(rst, d1, d5);
    sample_pop(tag);
    #0.35;
    hold_chk({tag, "_fall"});
    #0.15;
  endtask

  initial begin
    logic       r;
    logic       rd1;
    logic [4:0] rd5;

    #0.25;
    // Power-up with reset high and D opposite to the reset value: reset wins.
    cycle("pwrup_rst", 1'b1, 1'b1, 5'b01010);
    // Reset released: first capture happens at this edge, not earlier.
    cycle("rst_release", 1'b0, 1'b1, 5'b01010);

    // Basic capture: 0, 1, 1 (holds through an edge), 0
    cycle("cap0",      1'b0, 1'b0, 5'b00000);
    cycle("cap1",      1'b0, 1'b1, 5'b11111);
    cycle("cap1_hold", 1'b0, 1'b1, 5'b00110);
    cycle("cap0b",     1'b0, 1'b0, 5'b11001);

    // Hold between edges: D toggles within one window, Q must not follow.
    drive(1'b0, 1'b1, 5'b11111);
    sample_pop("hold_pre");
    #0.05; D1 = 1'b0; D5 = 5'b00000;
    #0.1;  D1 = 1'b1; D5 = 5'b11111;
    #0.1;  D1 = 1'b0; D5 = 5'b00000;
    #0.1;  hold_chk("hold_mid");
    drive(1'b0, 1'b0, 5'b00000);
    sample_pop("hold_cap");

    // Mid-stream reset raised 0.25 ns past an edge.
    drive(1'b0, 1'b1, 5'b01110);
    sample_pop("pre_rst");
    drive(1'b1, 1'b1, 5'b01010);
    #0.35;
    hold_chk("rst_no_async");
    sample_pop("rst_sync");
    drive(1'b1, 1'b1, 5'b11111);
    #0.35;
    hold_chk("rst_held_mid");
    sample_pop("rst_held");
    // Release reset between edges with D=1: Q stays at reset value until the edge.
    drive(1'b0, 1'b1, 5'b01010);
    #0.35;
    hold_chk("rel_pre");
    sample_pop("rel_cap");
    #0.5;

    // Random traffic with occasional resets
    for (int i = 0; i < 24; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      rd1 = 1'($urandom);
      rd5 = 5'($urandom);
      cycle("rand", r, rd1, rd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
